// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam int          INST_ADDR_W = 32;
  localparam logic        RST_ENABLE  = 1'b0;
  localparam logic        STOP        = 1'b1;
  localparam logic        NOSTOP      = 1'b0;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] PC_INIT     = 32'h0000_0000;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } if_state_e;

  // Sequential successor of a fetch address; wraps mod 2^32.
  function automatic logic [INST_ADDR_W-1:0] pc_inc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// One-entry buffer for a branch redirect that arrives while the PC is frozen.
// A newer capture overwrites an older one; clear wins over nothing (the two
// are never asserted together by the fetch stage).
module if_redirect_buf
  import if_stage_pkg::*;
(
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst_n,
  input  logic                   capture,
  input  logic                   clear,
  input  logic [INST_ADDR_W-1:0] br_addr,
  output logic                   pend_vld,
  output logic [INST_ADDR_W-1:0] pend_addr
);

  // Hold the most recent frozen-time branch target until it is consumed or flushed.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      pend_vld  <= 1'b0;
      pend_addr <= ZERO_WORD;
    end else if (capture) begin
      pend_vld  <= 1'b1;
      pend_addr <= br_addr;
    end else if (clear) begin
      pend_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives imem ice/iaddr and feeds
// if_pc / if_pc_plus4 to the IF/ID register.
// Optional macro IF_MISALIGN_CHECK_EN: flags misaligned fetch addresses on
// if_adel and suppresses the fetch; without it if_adel is constant 0.
//
// state   | meaning
// S_IDLE  | just out of reset, no fetch issued, PC = RESET_PC
// S_FETCH | fetching at if_pc (ice=1 unless if_adel is set)
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_INIT,
  parameter int          STALL_W  = 6
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [31:0]        flush_addr,
  input  logic               br_taken,
  input  logic [31:0]        br_addr,
  input  logic               imem_ack,
  output logic               ice,
  output logic [31:0]        iaddr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic               fetch_stall_req,
  output logic               if_adel
);

  if_state_e   state;
  logic [31:0] pc_q;
  logic        ice_q;
  logic        adel_q;
  logic        adv;
  logic [31:0] next_pc;
  logic        next_adel;
  logic        pend_vld;
  logic [31:0] pend_addr;
  logic        buf_capture;
  logic        buf_clear;
  logic        unused_stall;

  // Only the PC-freeze bit of the stall bus matters here.
  assign unused_stall = ^stall[STALL_W-1:1];

  // A fetch completes only when one is actually on the bus and the PC is not frozen.
  assign adv = (state == S_FETCH) && ice_q && (stall[0] == NOSTOP) && imem_ack;

  // Next-PC priority: flush, live branch, buffered branch, sequential, hold.
  always_comb begin
    next_pc = pc_q;
    if (flush)
      next_pc = flush_addr;
    else if (adv && br_taken)
      next_pc = br_addr;
    else if (adv && pend_vld)
      next_pc = pend_addr;
    else if (adv)
      next_pc = pc_inc(pc_q);
  end

`ifdef IF_MISALIGN_CHECK_EN
  // Address error follows the PC; flush always clears it.
  always_comb begin
    next_adel = adel_q;
    if (flush)
      next_adel = 1'b0;
    else if (adv)
      next_adel = (next_pc[1:0] != 2'b00);
  end
`else
  assign next_adel = 1'b0;
`endif

  // A branch that cannot be taken now is parked; a simultaneous flush drops it.
  assign buf_capture = br_taken && !adv && !flush;
  assign buf_clear   = flush || adv;

  if_redirect_buf u_redirect_buf (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .capture     (buf_capture),
    .clear       (buf_clear),
    .br_addr     (br_addr),
    .pend_vld    (pend_vld),
    .pend_addr   (pend_addr)
  );

  // Fetch FSM with registered PC, chip enable and address-error flag.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      ice_q  <= 1'b0;
      adel_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state  <= S_FETCH;
          pc_q   <= next_pc;
          ice_q  <= !next_adel;
          adel_q <= next_adel;
        end
        S_FETCH: begin
          pc_q   <= next_pc;
          ice_q  <= !next_adel;
          adel_q <= next_adel;
        end
        default: begin
          state  <= S_IDLE;
          ice_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ice             = ice_q;
  assign iaddr           = pc_q;
  assign if_pc           = pc_q;
  assign if_pc_plus4     = pc_inc(pc_q);
  assign if_adel         = adel_q;
  assign fetch_stall_req = (state == S_FETCH) && ice_q && !imem_ack;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a behavioural next-PC model.
module tb_if_stage;

  logic        cpu_clk_50M;
  logic        cpu_rst_n;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_addr;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        imem_ack;
  logic        ice;
  logic [31:0] iaddr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_stall_req;
  logic        if_adel;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_pv;
  logic [31:0] m_pa;
  bit          m_adel;

  if_stage #(.RESET_PC(32'h0000_0000), .STALL_W(6)) dut (
    .cpu_clk_50M     (cpu_clk_50M),
    .cpu_rst_n       (cpu_rst_n),
    .stall           (stall),
    .flush           (flush),
    .flush_addr      (flush_addr),
    .br_taken        (br_taken),
    .br_addr         (br_addr),
    .imem_ack        (imem_ack),
    .ice             (ice),
    .iaddr           (iaddr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .fetch_stall_req (fetch_stall_req),
    .if_adel         (if_adel)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic model_reset();
    m_run = 0; m_pc = 32'h0; m_pv = 0; m_pa = 32'h0; m_adel = 0;
  endtask

  // Apply the fetch rules to the current inputs, then advance one clock.
  task automatic tick();
    bit          fetching, go, n_pv, n_adel;
    logic [31:0] n_pc, n_pa;
    fetching = m_run && !m_adel;
    go       = fetching && !stall[0] && imem_ack;
    n_pc = m_pc; n_pv = m_pv; n_pa = m_pa; n_adel = m_adel;
    if (flush) begin
      n_pc = flush_addr; n_pv = 0; n_adel = 0;
    end else if (go) begin
      if (br_taken)  n_pc = br_addr;
      else if (m_pv) n_pc = m_pa;
      else           n_pc = m_pc + 32'd4;
      n_pv = 0;
`ifdef IF_MISALIGN_CHECK_EN
      n_adel = (n_pc % 4) != 0;
`endif
    end else if (br_taken) begin
      n_pv = 1; n_pa = br_addr;
    end
    @(posedge cpu_clk_50M);
    m_run = 1; m_pc = n_pc; m_pv = n_pv; m_pa = n_pa; m_adel = n_adel;
    @(negedge cpu_clk_50M);
  endtask

  task automatic idle_inputs();
    stall = 6'h0; flush = 0; flush_addr = 32'h0; br_taken = 0; br_addr = 32'h0; imem_ack = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    cpu_rst_n = 0;
    model_reset();
    repeat (2) @(negedge cpu_clk_50M);
    #1;
    checks++; if (ice !== 1'b0) begin errors++; $display("FAIL reset_ice got %b want 0", ice); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (fetch_stall_req !== 1'b0) begin errors++; $display("FAIL reset_fsr got %b want 0", fetch_stall_req); end
    checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL reset_adel got %b want 0", if_adel); end
    cpu_rst_n = 1;
    #1;
    checks++; if (ice !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL cyc1 ice=%b pc=%h want 0/0", ice, if_pc); end
    tick(); #1;
    checks++; if (ice !== 1'b1 || iaddr !== 32'h0) begin errors++; $display("FAIL cyc2 ice=%b iaddr=%h want 1/0", ice, iaddr); end
    tick(); #1;
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL seq4 got %h want 4", if_pc); end
    tick(); #1;
    checks++; if (if_pc !== 32'h8 || if_pc_plus4 !== 32'hC) begin errors++; $display("FAIL seq8 pc=%h p4=%h want 8/c", if_pc, if_pc_plus4); end
  endtask

  task automatic test_backpressure();
    flush = 1; flush_addr = 32'h10; tick(); flush = 0; #1;
    checks++; if (if_pc !== 32'h10) begin errors++; $display("FAIL bp_start got %h want 10", if_pc); end
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fetch_stall_req !== 1'b1 || if_pc !== 32'h10) begin
        errors++; $display("FAIL bp_hold%0d fsr=%b pc=%h want 1/10", i, fetch_stall_req, if_pc);
      end
      tick();
    end
    imem_ack = 1; #1;
    checks++; if (fetch_stall_req !== 1'b0) begin errors++; $display("FAIL bp_release fsr=%b want 0", fetch_stall_req); end
    tick(); #1;
    checks++; if (if_pc !== 32'h14) begin errors++; $display("FAIL bp_adv got %h want 14", if_pc); end
  endtask

  task automatic test_stall_branch();
    flush = 1; flush_addr = 32'h40; tick(); flush = 0;
    stall = 6'h01; br_taken = 1; br_addr = 32'h200; tick(); br_taken = 0; #1;
    checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL stall_hold got %h want 40", if_pc); end
    tick(); #1;
    checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL stall_hold2 got %h want 40", if_pc); end
    stall = 6'h0; tick(); #1;
    checks++; if (if_pc !== 32'h200) begin errors++; $display("FAIL pend_redirect got %h want 200", if_pc); end
    tick(); #1;
    checks++; if (if_pc !== 32'h204) begin errors++; $display("FAIL pend_next got %h want 204", if_pc); end
    // newest frozen branch wins
    stall = 6'h01; br_taken = 1; br_addr = 32'h300; tick();
    br_addr = 32'h500; tick(); br_taken = 0; stall = 6'h0; tick(); #1;
    checks++; if (if_pc !== 32'h500) begin errors++; $display("FAIL pend_overwrite got %h want 500", if_pc); end
    // branch while advancing goes straight through
    br_taken = 1; br_addr = 32'h600; tick(); br_taken = 0; #1;
    checks++; if (if_pc !== 32'h600) begin errors++; $display("FAIL br_direct got %h want 600", if_pc); end
  endtask

  task automatic test_flush_priority();
    stall = 6'h01; br_taken = 1; br_addr = 32'h300; tick();
    flush = 1; flush_addr = 32'hBFC0_0380; br_addr = 32'h400; tick();
    flush = 0; br_taken = 0; #1;
    checks++; if (if_pc !== 32'hBFC0_0380) begin errors++; $display("FAIL flush_pc got %h want bfc00380", if_pc); end
    stall = 6'h0; tick(); #1;
    checks++; if (if_pc !== 32'hBFC0_0384) begin errors++; $display("FAIL flush_drop got %h want bfc00384", if_pc); end
  endtask

  task automatic test_wrap();
    flush = 1; flush_addr = 32'hFFFF_FFFC; tick(); flush = 0; #1;
    checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_p4 got %h want 0", if_pc_plus4); end
    tick(); #1;
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", if_pc); end
  endtask

  task automatic test_async_reset();
    flush = 1; flush_addr = 32'h80; tick(); flush = 0;
    stall = 6'h01; br_taken = 1; br_addr = 32'h300; tick(); br_taken = 0;
    #2 cpu_rst_n = 0;
    #1;
    checks++; if (if_pc !== 32'h0 || ice !== 1'b0 || iaddr !== 32'h0) begin
      errors++; $display("FAIL async_rst pc=%h ice=%b iaddr=%h want 0/0/0", if_pc, ice, iaddr);
    end
    model_reset();
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1; stall = 6'h0; #1;
    checks++; if (ice !== 1'b0) begin errors++; $display("FAIL async_idle ice=%b want 0", ice); end
    tick(); #1;
    checks++; if (ice !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL async_first ice=%b pc=%h want 1/0", ice, if_pc); end
    tick(); #1;
    checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL async_pend_gone got %h want 4", if_pc); end
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    flush = 1; flush_addr = 32'h100; tick(); flush = 0;
    br_taken = 1; br_addr = 32'h102; tick(); br_taken = 0; imem_ack = 0; #1;
    checks++; if (if_adel !== 1'b1 || ice !== 1'b0 || fetch_stall_req !== 1'b0) begin
      errors++; $display("FAIL adel_set adel=%b ice=%b fsr=%b want 1/0/0", if_adel, ice, fetch_stall_req);
    end
    imem_ack = 1; tick(); #1;
    checks++; if (if_pc !== 32'h102) begin errors++; $display("FAIL adel_hold got %h want 102", if_pc); end
    flush = 1; flush_addr = 32'h200; tick(); flush = 0; #1;
    checks++; if (if_adel !== 1'b0 || ice !== 1'b1) begin errors++; $display("FAIL adel_clear adel=%b ice=%b want 0/1", if_adel, ice); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 3) == 0) ? 6'h01 : 6'h00;
      imem_ack   = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      flush_addr = $urandom & 32'hFFFF_FFFC;
      br_taken   = ($urandom_range(0, 3) == 0);
      br_addr    = $urandom & 32'hFFFF_FFFC;
`ifdef IF_MISALIGN_CHECK_EN
      if ($urandom_range(0, 15) == 0) br_addr = br_addr | 32'h2;
`endif
      #1;
      checks++;
      if (if_pc !== m_pc || iaddr !== m_pc || if_pc_plus4 !== m_pc + 32'd4) begin
        errors++; $display("FAIL rand_pc[%0d] pc=%h iaddr=%h p4=%h want %h", i, if_pc, iaddr, if_pc_plus4, m_pc);
      end
      checks++;
      if (ice !== (m_run && !m_adel) || if_adel !== m_adel) begin
        errors++; $display("FAIL rand_ice[%0d] ice=%b adel=%b want %b/%b", i, ice, if_adel, m_run && !m_adel, m_adel);
      end
      checks++;
      if (fetch_stall_req !== (m_run && !m_adel && !imem_ack)) begin
        errors++; $display("FAIL rand_fsr[%0d] got %b want %b", i, fetch_stall_req, m_run && !m_adel && !imem_ack);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_backpressure();
    idle_inputs();
    test_stall_branch();
    idle_inputs();
    test_flush_priority();
    idle_inputs();
    test_wrap();
    test_async_reset();
    idle_inputs();
`ifdef IF_MISALIGN_CHECK_EN
    test_misalign();
    idle_inputs();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory chip-enable and address.
- Produces if_pc and if_pc_plus4 for the IF/ID register.
- Resolves next-PC from flush, branch redirect, stall and imem back-pressure, and buffers a branch redirect that arrives while the PC is frozen.

Parameters:
- RESET_PC, 32'h0000_0000, PC value held during and immediately after reset.
- STALL_W, 6, width of the pipeline stall bus; bit 0 = PC, bit 1 = IF.

Ports:
- cpu_clk_50M  in  1  system clock; all state updates on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- stall  in  STALL_W  pipeline stall vector; stall[0]==STOP freezes the PC.
- flush  in  1  exception/ERET flush; highest priority.
- flush_addr  in  32  redirect target when flush=1.
- br_taken  in  1  branch/jump resolved taken in ID (one-cycle pulse).
- br_addr  in  32  branch target, valid with br_taken.
- imem_ack  in  1  imem accepted iaddr this cycle (combinational, same cycle as ice).
- ice  out  1  instruction memory chip enable.
- iaddr  out  32  instruction address, equal to if_pc.
- if_pc  out  32  PC of the instruction being fetched, to IF/ID.
- if_pc_plus4  out  32  if_pc + 4, to IF/ID.
- fetch_stall_req  out  1  stall request to the stall controller while ice=1 and imem_ack=0.
- if_adel  out  1  fetch address-error flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock (cpu_clk_50M); reset is asynchronous and active-low (cpu_rst_n).
- Reset values: state=IDLE, if_pc=RESET_PC, ice=0, pend_vld=0, pend_addr=0, if_adel=0. if_pc_plus4 = if_pc+4 combinationally.
- FSM states:
  - IDLE: ice=0; entered only from reset; moves to FETCH on the first clock after reset release. if_pc stays RESET_PC, so RESET_PC is the first fetched address.
  - FETCH: ice=1 (0 if if_adel=1); iaddr=if_pc. No other state exists.
- PC advances ("adv") when stall[0]==NOSTOP and imem_ack==1.
- next_pc priority:
  1. flush=1 -> flush_addr. Applied even when the PC is frozen or imem_ack=0. Clears pend_vld.
  2. adv and br_taken -> br_addr.
  3. adv and pend_vld -> pend_addr; clears pend_vld.
  4. adv -> if_pc+4, wrapping mod 2^32.
  5. otherwise -> hold if_pc.
- Pending-branch capture: br_taken=1 while not adv and flush=0 sets pend_vld=1 and pend_addr=br_addr.
  - A second br_taken while pend_vld=1 overwrites pend_addr (newest wins).
- Simultaneous flush and br_taken: flush wins; the branch is dropped and not buffered.
- fetch_stall_req = (state==FETCH) & ice & ~imem_ack. Combinational, zero latency.
- Latency: a redirect accepted in cycle N appears on if_pc/iaddr in cycle N+1.
- Asynchronous reset mid-fetch: outputs go to reset values immediately; the outstanding request is abandoned.

Optional Feature:
- Macro: IF_MISALIGN_CHECK_EN.
- Defined:
  - if_adel is registered as (next_pc[1:0] != 0), updated together with if_pc.
  - While if_adel=1, ice=0 and fetch_stall_req=0 (the fetch is suppressed and the exception is left to downstream).
  - flush clears if_adel.
- Undefined: if_adel is tied to 0 and no check logic exists.

Decomposition:
- The shared header define.vh holds RST_ENABLE, STOP, NOSTOP, ZERO_WORD, INST_ADDR_BUS, STALL_BUS and a new PC_INIT constant, the default for RESET_PC.
- Sub-module if_redirect_buf holds pend_vld/pend_addr with capture, overwrite and clear inputs; reset is asynchronous active-low.
- The FSM and next-PC mux stay in if_stage.

Test Plan:
- Reset then release, imem_ack=1, stall=0: cycle 1 ice=0, if_pc=0x0; cycle 2 ice=1, iaddr=0x0; then 0x4, 0x8 on consecutive cycles.
- imem_ack=0 for 3 cycles at pc=0x10: fetch_stall_req=1 for exactly those 3 cycles, if_pc held at 0x10; then 0x14 one cycle after ack.
- stall[0]=STOP with br_taken pulse (br_addr=0x200) at pc=0x40: if_pc stays 0x40 and pend_vld=1; on release if_pc=0x200, then 0x204.
- flush=1 (flush_addr=0xBFC00380) with br_taken=1 and stall[0]=STOP, pend_vld=1: next if_pc=0xBFC00380, pend_vld=0, branch dropped.
- cpu_rst_n low mid-FETCH at pc=0x80 with pend_vld=1: immediately if_pc=0x0, ice=0, pend_vld=0.
- With IF_MISALIGN_CHECK_EN, br_addr=0x102: if_adel=1, ice=0, fetch_stall_req=0; a following flush clears if_adel.
